// File: rtl/multi_trigger_fire_ctrl_if.sv
// Market-data, channel-config and fire-report bundle for multi_trigger_fire_ctrl.
// Latency: none; this file only groups the signals.
// Backpressure: none; every field is a single-cycle qualified strobe or a level.
interface multi_trigger_fire_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              md_valid;
    logic [31:0]       md_sec_id;
    logic [63:0]       md_price;
    logic [31:0]       md_size;
    logic [1:0]        md_side;

    logic              cfg_wr;
    logic [IDX_W-1:0]  cfg_idx;
    logic              cfg_en;
    logic              cfg_shift;
    logic [31:0]       cfg_sec_id;
    logic [63:0]       cfg_price_lo;
    logic [63:0]       cfg_price_hi;
    logic [31:0]       cfg_size_lo;
    logic [31:0]       cfg_size_hi;

    logic [NUM_CH-1:0] ch_armed;
    logic [NUM_CH-1:0] fires;
    logic              fire;
    logic              rpt_valid;
    logic [IDX_W-1:0]  rpt_idx;
    logic [63:0]       rpt_price;
    logic [1:0]        rpt_side;
    logic [31:0]       fire_count;

    modport master (
        output md_valid, md_sec_id, md_price, md_size, md_side,
        output cfg_wr, cfg_idx, cfg_en, cfg_shift, cfg_sec_id,
        output cfg_price_lo, cfg_price_hi, cfg_size_lo, cfg_size_hi,
        input  ch_armed, fires, fire, rpt_valid, rpt_idx, rpt_price, rpt_side, fire_count
    );

    modport slave (
        input  md_valid, md_sec_id, md_price, md_size, md_side,
        input  cfg_wr, cfg_idx, cfg_en, cfg_shift, cfg_sec_id,
        input  cfg_price_lo, cfg_price_hi, cfg_size_lo, cfg_size_hi,
        output ch_armed, fires, fire, rpt_valid, rpt_idx, rpt_price, rpt_side, fire_count
    );
endinterface

// File: rtl/multi_trigger_fire_ctrl.sv
// N-channel window trigger: arm / fire pulse / holdoff / re-arm per channel, aggregate fire report.
// Latency: match sampled at edge N shows on fires/rpt_valid in cycle N+1.
// Backpressure: none; matches arriving while a channel is busy are dropped.
module multi_trigger_fire_ctrl #(
    parameter int NUM_CH         = 4,
    parameter int FIRE_CYCLES    = 1,
    parameter int HOLDOFF_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    multi_trigger_fire_ctrl_if.slave  bus
);
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_MAX = (FIRE_CYCLES > HOLDOFF_CYCLES) ? FIRE_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_FIRING,
        ST_HOLDOFF
    } ch_state_t;

    typedef struct packed {
        logic        shift;
        logic [31:0] sec_id;
        logic [63:0] price_lo;
        logic [63:0] price_hi;
        logic [31:0] size_lo;
        logic [31:0] size_hi;
    } ch_cfg_t;

    ch_cfg_t          cfg_q   [NUM_CH];
    ch_state_t        state_q [NUM_CH];
    logic [CNT_W-1:0] cnt_q   [NUM_CH];
    logic [NUM_CH-1:0] armed_q;
    logic [NUM_CH-1:0] fires_q;

    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] match;
    logic [NUM_CH-1:0] hit;
    logic [63:0]       half   [NUM_CH];
    logic [63:0]       new_lo [NUM_CH];
    logic [64:0]       hi_sum [NUM_CH];
    logic [63:0]       new_hi [NUM_CH];
    logic [IDX_W-1:0]  low_idx;

    logic              rpt_valid_q;
    logic [IDX_W-1:0]  rpt_idx_q;
    logic [63:0]       rpt_price_q;
    logic [1:0]        rpt_side_q;
    logic [31:0]       fire_count_q;

    // A config write to a channel suppresses its match in the same cycle.
    always_comb begin
        wr_sel = '0;
        match  = '0;
        hit    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = bus.cfg_wr && (bus.cfg_idx == IDX_W'(i));
            match[i]  = bus.md_valid
                     && (bus.md_sec_id == cfg_q[i].sec_id)
                     && (bus.md_price  >= cfg_q[i].price_lo)
                     && (bus.md_price  <= cfg_q[i].price_hi)
                     && (bus.md_size   >= cfg_q[i].size_lo)
                     && (bus.md_size   <= cfg_q[i].size_hi);
            hit[i]    = match[i] && (state_q[i] == ST_ARMED) && !wr_sel[i];
        end
    end

    // Re-centred window around the hit price, half-width taken from the current window.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            half[i]   = (cfg_q[i].price_hi - cfg_q[i].price_lo) >> 1;
            new_lo[i] = (bus.md_price > half[i]) ? (bus.md_price - half[i]) : '0;
            hi_sum[i] = {1'b0, bus.md_price} + {1'b0, half[i]};
            new_hi[i] = hi_sum[i][64] ? '1 : hi_sum[i][63:0];
        end
    end

    always_comb begin
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cfg_q[i]   <= '0;
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            armed_q <= '0;
            fires_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_sel[i]) begin
                    cfg_q[i].shift    <= bus.cfg_shift;
                    cfg_q[i].sec_id   <= bus.cfg_sec_id;
                    cfg_q[i].price_lo <= bus.cfg_price_lo;
                    cfg_q[i].price_hi <= bus.cfg_price_hi;
                    cfg_q[i].size_lo  <= bus.cfg_size_lo;
                    cfg_q[i].size_hi  <= bus.cfg_size_hi;
                    state_q[i]        <= bus.cfg_en ? ST_ARMED : ST_IDLE;
                    cnt_q[i]          <= '0;
                    armed_q[i]        <= bus.cfg_en;
                    fires_q[i]        <= 1'b0;
                end else begin
                    case (state_q[i])
                        ST_ARMED: begin
                            if (hit[i]) begin
                                state_q[i] <= ST_FIRING;
                                cnt_q[i]   <= CNT_W'(FIRE_CYCLES - 1);
                                armed_q[i] <= 1'b0;
                                fires_q[i] <= 1'b1;
                                if (cfg_q[i].shift) begin
                                    cfg_q[i].price_lo <= new_lo[i];
                                    cfg_q[i].price_hi <= new_hi[i];
                                end
                            end
                        end
                        ST_FIRING: begin
                            if (cnt_q[i] == '0) begin
                                fires_q[i] <= 1'b0;
                                if (HOLDOFF_CYCLES == 0) begin
                                    state_q[i] <= ST_ARMED;
                                    armed_q[i] <= 1'b1;
                                end else begin
                                    state_q[i] <= ST_HOLDOFF;
                                    cnt_q[i]   <= CNT_W'(HOLDOFF_CYCLES - 1);
                                end
                            end else begin
                                cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                            end
                        end
                        ST_HOLDOFF: begin
                            if (cnt_q[i] == '0) begin
                                state_q[i] <= ST_ARMED;
                                armed_q[i] <= 1'b1;
                            end else begin
                                cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // One report per event, however many channels fired together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_valid_q  <= 1'b0;
            rpt_idx_q    <= '0;
            rpt_price_q  <= '0;
            rpt_side_q   <= '0;
            fire_count_q <= '0;
        end else begin
            rpt_valid_q <= |hit;
            if (|hit) begin
                rpt_idx_q    <= low_idx;
                rpt_price_q  <= bus.md_price;
                rpt_side_q   <= bus.md_side;
                fire_count_q <= fire_count_q + 32'd1;
            end
        end
    end

    assign bus.ch_armed   = armed_q;
    assign bus.fires      = fires_q;
    assign bus.fire       = |fires_q;
    assign bus.rpt_valid  = rpt_valid_q;
    assign bus.rpt_idx    = rpt_idx_q;
    assign bus.rpt_price  = rpt_price_q;
    assign bus.rpt_side   = rpt_side_q;
    assign bus.fire_count = fire_count_q;
endmodule

// File: tb/tb_multi_trigger_fire_ctrl.sv
// Randomised and directed bench for multi_trigger_fire_ctrl against a cycle-number based model.
module tb_multi_trigger_fire_ctrl;
    localparam int NUM_CH = 6;
    localparam int FC     = 2;
    localparam int HC     = 3;
    localparam int IDX_W  = 3;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multi_trigger_fire_ctrl_if #(.NUM_CH(NUM_CH)) bus ();

    multi_trigger_fire_ctrl #(
        .NUM_CH(NUM_CH), .FIRE_CYCLES(FC), .HOLDOFF_CYCLES(HC)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Model: each channel remembers the edge it last fired on; everything else follows by arithmetic.
    longint      t;
    bit          m_en    [NUM_CH];
    bit          m_shift [NUM_CH];
    logic [31:0] m_sec   [NUM_CH];
    logic [63:0] m_plo   [NUM_CH];
    logic [63:0] m_phi   [NUM_CH];
    logic [31:0] m_slo   [NUM_CH];
    logic [31:0] m_shi   [NUM_CH];
    longint      m_lf    [NUM_CH];
    bit               e_rvld;
    logic [IDX_W-1:0] e_idx;
    logic [63:0]      e_price;
    logic [1:0]       e_side;
    logic [31:0]      e_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_en[i] = 0; m_shift[i] = 0; m_sec[i] = '0; m_plo[i] = '0; m_phi[i] = '0;
            m_slo[i] = '0; m_shi[i] = '0; m_lf[i] = -1000;
        end
        e_rvld = 0; e_idx = '0; e_price = '0; e_side = '0; e_count = '0;
    endtask

    always @(posedge clk or negedge rst) begin : mdl
        logic [NUM_CH-1:0] h;
        int          low;
        bit          wr, mt;
        logic [63:0] half, pr;
        if (!rst) begin
            model_reset();
        end else begin
            t++;
            h   = '0;
            low = -1;
            pr  = bus.md_price;
            for (int i = 0; i < NUM_CH; i++) begin
                wr = bus.cfg_wr && (bus.cfg_idx == i);
                mt = bus.md_valid && bus.md_sec_id == m_sec[i] && pr >= m_plo[i] && pr <= m_phi[i]
                     && bus.md_size >= m_slo[i] && bus.md_size <= m_shi[i];
                if (wr) begin
                    m_en[i] = bus.cfg_en; m_shift[i] = bus.cfg_shift; m_sec[i] = bus.cfg_sec_id;
                    m_plo[i] = bus.cfg_price_lo; m_phi[i] = bus.cfg_price_hi;
                    m_slo[i] = bus.cfg_size_lo; m_shi[i] = bus.cfg_size_hi;
                    m_lf[i] = -1000;
                end else if (mt && m_en[i] && t >= m_lf[i] + FC + HC + 1) begin
                    h[i] = 1'b1;
                    if (low < 0) low = i;
                    m_lf[i] = t;
                    if (m_shift[i]) begin
                        half = (m_phi[i] - m_plo[i]) >> 1;
                        m_plo[i] = (pr < half) ? 64'd0 : pr - half;
                        m_phi[i] = (pr > ALL1 - half) ? ALL1 : pr + half;
                    end
                end
            end
            e_rvld = |h;
            if (|h) begin
                e_idx   = low[IDX_W-1:0];
                e_price = pr;
                e_side  = bus.md_side;
                e_count = e_count + 1;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [NUM_CH-1:0] ef, ea;
        for (int i = 0; i < NUM_CH; i++) begin
            ef[i] = (t - m_lf[i]) < FC;
            ea[i] = m_en[i] && (t - m_lf[i]) >= FC + HC;
        end
        chk("fires",      bus.fires,      ef);
        chk("fire",       bus.fire,       |ef);
        chk("ch_armed",   bus.ch_armed,   ea);
        chk("rpt_valid",  bus.rpt_valid,  e_rvld);
        chk("rpt_idx",    bus.rpt_idx,    e_idx);
        chk("rpt_price",  bus.rpt_price,  e_price);
        chk("rpt_side",   bus.rpt_side,   e_side);
        chk("fire_count", bus.fire_count, e_count);
    end

    task automatic tick();
        @(negedge clk);
        bus.cfg_wr   = 1'b0;
        bus.md_valid = 1'b0;
    endtask

    task automatic cfg_write(input int idx, input bit en, input bit sh, input logic [31:0] sec,
                             input logic [63:0] plo, input logic [63:0] phi,
                             input logic [31:0] slo, input logic [31:0] shi);
        bus.cfg_wr = 1'b1; bus.cfg_idx = idx[IDX_W-1:0]; bus.cfg_en = en; bus.cfg_shift = sh;
        bus.cfg_sec_id = sec; bus.cfg_price_lo = plo; bus.cfg_price_hi = phi;
        bus.cfg_size_lo = slo; bus.cfg_size_hi = shi;
    endtask

    task automatic md(input logic [31:0] sec, input logic [63:0] price,
                      input logic [31:0] size, input logic [1:0] side);
        bus.md_valid = 1'b1; bus.md_sec_id = sec; bus.md_price = price;
        bus.md_size = size; bus.md_side = side;
    endtask

    function automatic logic [63:0] rp();
        if ($urandom_range(0, 7) == 0) return 64'hFFFF_FFFF_FFFF_FE00 + 64'($urandom_range(0, 511));
        return 64'($urandom_range(0, 400));
    endfunction

    initial begin
        logic [63:0] plo;
        t = 0;
        bus.md_valid = 0; bus.md_sec_id = '0; bus.md_price = '0; bus.md_size = '0; bus.md_side = '0;
        cfg_write(0, 0, 0, 0, 0, 0, 0, 0);
        bus.cfg_wr = 1'b0;
        repeat (3) tick();
        chk("rst_fires", bus.fires, 0);
        chk("rst_count", bus.fire_count, 0);
        chk("rst_armed", bus.ch_armed, 0);
        rst = 1'b1;

        // Basic fire and report
        cfg_write(0, 1, 0, 1, 100, 200, 1, 5); tick();
        md(1, 150, 3, 2); tick();
        chk("t1_fires", bus.fires, 6'b000001);
        chk("t1_rvld", bus.rpt_valid, 1);
        chk("t1_idx", bus.rpt_idx, 0);
        chk("t1_price", bus.rpt_price, 150);
        chk("t1_side", bus.rpt_side, 2);
        chk("t1_count", bus.fire_count, 1);
        // Matches during pulse/holdoff are dropped; first match after re-arm fires
        for (int k = 1; k <= FC + HC; k++) begin
            md(1, 150, 3, 2); tick();
            if (k == 1) begin
                chk("t2_pulse_w", bus.fires, 6'b000001);
                chk("t2_rvld_1cyc", bus.rpt_valid, 0);
            end
        end
        chk("t2_dropped", bus.fire_count, 1);
        chk("t2_rearmed", bus.ch_armed[0], 1);
        md(1, 150, 3, 2); tick();
        chk("t2_refire", bus.fire_count, 2);

        // Shift mode: [100,200] hit at 190 -> [140,240]
        cfg_write(0, 1, 1, 1, 100, 200, 1, 5); tick();
        md(1, 190, 3, 0); tick();
        chk("t3_fire", bus.fire_count, 3);
        repeat (FC + HC) tick();
        md(1, 139, 3, 0); tick();
        chk("t3_oldlo_gone", bus.fire_count, 3);
        md(1, 240, 3, 1); tick();
        chk("t3_newhi", bus.fire_count, 4);
        chk("t3_price", bus.rpt_price, 240);
        // [0,100] hit at 20 -> [0,70]
        cfg_write(0, 1, 1, 1, 0, 100, 1, 5); tick();
        md(1, 20, 3, 0); tick();
        repeat (FC + HC) tick();
        md(1, 71, 3, 0); tick();
        chk("t3_lo_sat_71", bus.fire_count, 5);
        md(1, 70, 3, 0); tick();
        chk("t3_lo_sat_70", bus.fire_count, 6);
        // Upper saturation
        cfg_write(0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FF00, ALL1, 1, 5); tick();
        md(1, 64'hFFFF_FFFF_FFFF_FFF0, 3, 0); tick();
        repeat (FC + HC) tick();
        md(1, 64'hFFFF_FFFF_FFFF_FF70, 3, 0); tick();
        chk("t3_hi_sat_lo", bus.fire_count, 7);
        md(1, ALL1, 3, 0); tick();
        chk("t3_hi_sat_top", bus.fire_count, 8);

        // Two channels on one event
        cfg_write(0, 0, 0, 0, 0, 0, 0, 0); tick();
        cfg_write(1, 1, 0, 7, 400, 600, 0, 100); tick();
        cfg_write(3, 1, 0, 7, 400, 600, 0, 100); tick();
        md(7, 500, 10, 3); tick();
        chk("t4_fires", bus.fires, 6'b001010);
        chk("t4_idx", bus.rpt_idx, 1);
        chk("t4_count", bus.fire_count, 9);

        // Config write beats a same-cycle match
        cfg_write(0, 1, 0, 1, 100, 200, 1, 5); tick();
        cfg_write(0, 1, 0, 1, 300, 400, 1, 5); md(1, 150, 3, 0); tick();
        chk("t5_nofire", bus.fires[0], 0);
        chk("t5_count", bus.fire_count, 9);
        md(1, 150, 3, 0); tick();
        chk("t5_oldwin", bus.fire_count, 9);
        md(1, 350, 3, 0); tick();
        chk("t5_newwin", bus.fire_count, 10);
        repeat (FC + HC) tick();
        chk("t5_armed", bus.ch_armed, 6'b001011);
        cfg_write(7, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("t5_bad_idx7", bus.ch_armed, 6'b001011);
        cfg_write(6, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("t5_bad_idx6", bus.ch_armed, 6'b001011);

        // Reset mid-pulse
        md(1, 350, 3, 0); tick();
        chk("t6_firing", bus.fires[0], 1);
        #1 rst = 1'b0;
        #1;
        chk("t6_fires0", bus.fires, 0);
        chk("t6_armed0", bus.ch_armed, 0);
        chk("t6_count0", bus.fire_count, 0);
        chk("t6_rvld0", bus.rpt_valid, 0);
        tick();
        rst = 1'b1;
        md(1, 350, 3, 0); tick();
        chk("t6_ignored", bus.fire_count, 0);
        tick();
        chk("t6_nopulse", bus.fires, 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                plo = rp();
                cfg_write($urandom_range(0, 7), $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3), plo,
                          ($urandom_range(0, 5) == 0) ? plo - 64'($urandom_range(1, 50))
                                                      : plo + 64'($urandom_range(0, 300)),
                          $urandom_range(0, 10), $urandom_range(0, 20));
            end
            if ($urandom_range(0, 2) == 0) begin
                md($urandom_range(0, 3), rp(), $urandom_range(0, 15), 2'($urandom_range(0, 3)));
            end
            tick();
        end
        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
